// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size codes, FSM states
// and the captured request record.
package lsu_pkg;

  localparam int unsigned SizeW   = 2;
  localparam int unsigned LaneCnt = 4;
  localparam int unsigned CntW    = 8;

  typedef enum logic [SizeW-1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'b00,
    LSU_REQ  = 2'b01,
    LSU_DONE = 2'b10
  } lsu_state_e;

  typedef struct packed {
    logic       is_store;
    size_e      size;
    logic       load_signed;
    logic [1:0] offset;
  } lsu_req_t;

  // Natural alignment check for the requested size.
  function automatic logic size_legal(size_e size, logic [1:0] offset);
    case (size)
      SIZE_BYTE: size_legal = 1'b1;
      SIZE_HALF: size_legal = ~offset[0];
      SIZE_WORD: size_legal = (offset == 2'b00);
      default:   size_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store lane enables/replication, legality, and load
// lane extraction with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int unsigned DataSize = 32
) (
  input  logic [1:0]          size,
  input  logic [1:0]          offset,
  input  logic                load_signed,
  input  logic [DataSize-1:0] store_data,
  input  logic [DataSize-1:0] rdata,
  output logic [3:0]          be,
  output logic [DataSize-1:0] wdata,
  output logic                legal,
  output logic [DataSize-1:0] load_ext
);

  logic [7:0]  lane8;
  logic [15:0] lane16;

  always_comb begin
    be       = '0;
    wdata    = '0;
    load_ext = '0;
    lane8    = rdata[{offset, 3'b000} +: 8];
    lane16   = rdata[{offset[1], 4'b0000} +: 16];
    legal    = size_legal(size_e'(size), offset);
    case (size_e'(size))
      SIZE_BYTE: begin
        be       = 4'(4'b0001 << offset);
        wdata    = DataSize'({4{store_data[7:0]}});
        load_ext = {{(DataSize-8){load_signed & lane8[7]}}, lane8};
      end
      SIZE_HALF: begin
        be       = 4'(4'b0011 << offset);
        wdata    = DataSize'({2{store_data[15:0]}});
        load_ext = {{(DataSize-16){load_signed & lane16[15]}}, lane16};
      end
      SIZE_WORD: begin
        be       = 4'b1111;
        wdata    = store_data;
        load_ext = rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: captures a request, runs one req/ack memory access with a
// timeout, and returns the extended load value.
module lsu
  import lsu_pkg::*;
#(
  parameter int unsigned DataSize      = 32,
  parameter int unsigned AddrSize      = 32,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                is_store,
  input  logic [1:0]          access_size,
  input  logic                load_signed,
  input  logic [AddrSize-1:0] address,
  input  logic [DataSize-1:0] store_data,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [DataSize-1:0] load_data,
  output logic                mem_req,
  output logic                mem_we,
  output logic [AddrSize-1:0] mem_addr,
  output logic [3:0]          mem_be,
  output logic [DataSize-1:0] mem_wdata,
  input  logic [DataSize-1:0] mem_rdata,
  input  logic                mem_ack
);

  lsu_state_e          state_q, state_d;
  lsu_req_t            req_q;
  logic [CntW-1:0]     cnt_q;
  logic                idle, accept, timeout_hit;
  logic [1:0]          al_size, al_offset;
  logic                al_signed, al_legal;
  logic [3:0]          al_be;
  logic [DataSize-1:0] al_wdata, al_load;
  logic                busy_d, done_d, error_d, req_d, we_d;
  logic [3:0]          be_d;
  logic [AddrSize-1:0] addr_d;
  logic [DataSize-1:0] wdata_d;

  assign idle        = (state_q == LSU_IDLE);
  assign accept      = idle & start;
  assign timeout_hit = (cnt_q == CntW'(TimeoutCycles - 1));

  // In IDLE the aligner sees the live request; afterwards the captured one.
  assign al_size   = idle ? access_size : req_q.size;
  assign al_offset = idle ? address[1:0] : req_q.offset;
  assign al_signed = idle ? load_signed : req_q.load_signed;

  lsu_align #(.DataSize(DataSize)) u_align (
    .size        (al_size),
    .offset      (al_offset),
    .load_signed (al_signed),
    .store_data  (store_data),
    .rdata       (mem_rdata),
    .be          (al_be),
    .wdata       (al_wdata),
    .legal       (al_legal),
    .load_ext    (al_load)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= LSU_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LSU_IDLE: if (start) state_d = al_legal ? LSU_REQ : LSU_DONE;
      LSU_REQ:  if (mem_ack || timeout_hit) state_d = LSU_DONE;
      LSU_DONE: state_d = LSU_IDLE;
      default:  state_d = LSU_IDLE;
    endcase
  end

  // Next values of the registered outputs; memory fields are zero outside REQ.
  always_comb begin
    busy_d  = (state_d != LSU_IDLE);
    done_d  = (state_d == LSU_DONE);
    error_d = 1'b0;
    req_d   = 1'b0;
    we_d    = 1'b0;
    be_d    = '0;
    addr_d  = '0;
    wdata_d = '0;
    if (accept && !al_legal) error_d = 1'b1;
    if (state_q == LSU_REQ && !mem_ack && timeout_hit) error_d = 1'b1;
    if (state_d == LSU_REQ) begin
      req_d = 1'b1;
      if (idle) begin
        we_d    = is_store;
        be_d    = al_be;
        addr_d  = {address[AddrSize-1:2], 2'b00};
        wdata_d = al_wdata;
      end else begin
        we_d    = mem_we;
        be_d    = mem_be;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      busy      <= busy_d;
      done      <= done_d;
      error     <= error_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_be    <= be_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
    end
  end

  // Request capture, timeout counter and load result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q     <= '0;
      cnt_q     <= '0;
      load_data <= '0;
    end else begin
      if (accept) begin
        req_q <= '{is_store: is_store, size: size_e'(access_size),
                   load_signed: load_signed, offset: address[1:0]};
        cnt_q <= '0;
      end else if (state_q == LSU_REQ && !mem_ack) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (state_q == LSU_REQ && mem_ack && !req_q.is_store) load_data <= al_load;
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Randomised self-checking bench for lsu against an arithmetic reference model.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, is_store, load_signed, mem_ack;
  logic [1:0]  access_size;
  logic [31:0] address, store_data, mem_rdata;
  logic        busy, done, error, mem_req, mem_we;
  logic [31:0] load_data, mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] ld_model = '0;

  lsu dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store),
    .access_size(access_size), .load_signed(load_signed), .address(address),
    .store_data(store_data), .busy(busy), .done(done), .error(error),
    .load_data(load_data), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_legal(input int sz, input int off);
    if (sz == 3) return 1'b0;
    if (sz == 1) return (off % 2) == 0;
    if (sz == 2) return off == 0;
    return 1'b1;
  endfunction

  function automatic logic [3:0] m_be(input int sz, input int off);
    if (sz == 0) return 4'(1 << off);
    if (sz == 1) return 4'(3 << off);
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input int sz, input logic [31:0] d);
    if (sz == 0) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 1) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_load(input int sz, input int off, input bit sg,
                                         input logic [31:0] r);
    logic [31:0] v;
    v = r >> (8 * off);
    if (sz == 0) begin
      v = v & 32'hFF;
      if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 1) begin
      v = v & 32'hFFFF;
      if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = r;
    end
    return v;
  endfunction

  // One complete access; ack_cyc = 0 means the memory never acknowledges.
  task automatic do_access(input bit st, input logic [1:0] sz, input bit sg,
                           input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rd, input int ack_cyc, input string nm);
    bit          leg, acked;
    logic [3:0]  ebe;
    logic [31:0] ewd, ead;
    leg = m_legal(int'(sz), int'(a[1:0]));
    ebe = m_be(int'(sz), int'(a[1:0]));
    ewd = m_wdata(int'(sz), sd);
    ead = a & 32'hFFFF_FFFC;
    is_store = st; access_size = sz; load_signed = sg; address = a; store_data = sd;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (!leg) begin
      n_cmp++; if (done !== 1'b1 || error !== 1'b1) begin n_bad++;
        $display("FAIL %s illegal done/error: got %b/%b exp 1/1", nm, done, error); end
      n_cmp++; if (mem_req !== 1'b0) begin n_bad++;
        $display("FAIL %s illegal mem_req: got %b exp 0", nm, mem_req); end
      n_cmp++; if (load_data !== ld_model) begin n_bad++;
        $display("FAIL %s illegal load_data: got %h exp %h", nm, load_data, ld_model); end
      tick();
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++;
        $display("FAIL %s idle done/busy: got %b/%b exp 0/0", nm, done, busy); end
      return;
    end
    acked = 1'b0;
    for (int c = 1; c <= 255; c++) begin
      n_cmp++; if (mem_req !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin n_bad++;
        $display("FAIL %s req c%0d req/busy/done: got %b%b%b exp 110", nm, c, mem_req, busy, done); end
      n_cmp++; if (mem_addr !== ead || mem_be !== ebe || mem_we !== st) begin n_bad++;
        $display("FAIL %s req c%0d addr/be/we: got %h/%b/%b exp %h/%b/%b",
                 nm, c, mem_addr, mem_be, mem_we, ead, ebe, st); end
      n_cmp++; if (mem_wdata !== ewd) begin n_bad++;
        $display("FAIL %s req c%0d wdata: got %h exp %h", nm, c, mem_wdata, ewd); end
      if (c == 1) begin
        start = 1'b1; is_store = ~st; load_signed = ~sg;
        access_size = 2'($urandom); address = $urandom; store_data = $urandom;
      end else begin
        start = 1'b0;
      end
      if (c == ack_cyc) begin
        mem_ack = 1'b1; mem_rdata = rd;
        tick();
        mem_ack = 1'b0; mem_rdata = $urandom;
        acked = 1'b1;
        break;
      end
      tick();
    end
    start = 1'b0;
    if (acked && !st) ld_model = m_load(int'(sz), int'(a[1:0]), sg, rd);
    n_cmp++; if (done !== 1'b1 || error !== !acked) begin n_bad++;
      $display("FAIL %s done/error: got %b/%b exp 1/%b", nm, done, error, !acked); end
    n_cmp++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_be !== 4'h0 ||
                 mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin n_bad++;
      $display("FAIL %s mem idle: got req%b we%b be%b addr%h wd%h exp all zero",
               nm, mem_req, mem_we, mem_be, mem_addr, mem_wdata); end
    n_cmp++; if (load_data !== ld_model) begin n_bad++;
      $display("FAIL %s load_data: got %h exp %h", nm, load_data, ld_model); end
    tick();
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0 || error !== 1'b0) begin n_bad++;
      $display("FAIL %s after done: got done%b busy%b err%b exp 000", nm, done, busy, error); end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; is_store = 1'b0; access_size = 2'b00; load_signed = 1'b0;
    address = '0; store_data = '0; mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    n_cmp++; if ({busy, done, error, mem_req, mem_we} !== 5'b0 || mem_be !== 4'h0) begin n_bad++;
      $display("FAIL reset flags: got %b be %b exp 00000 be 0000",
               {busy, done, error, mem_req, mem_we}, mem_be); end
    n_cmp++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || load_data !== 32'h0) begin n_bad++;
      $display("FAIL reset data: got %h %h %h exp zeros", mem_addr, mem_wdata, load_data); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_word_load();
    do_access(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, 32'hDEAD_BEEF, 1, "word_load");
  endtask

  task automatic test_byte_load();
    do_access(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, 32'h8012_3456, 1, "byte_signed");
    do_access(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, 32'h8012_3456, 2, "byte_unsigned");
  endtask

  task automatic test_half_store();
    do_access(1'b1, 2'b01, 1'b0, 32'h202, 32'h1234_ABCD, 32'h5555_5555, 2, "half_store");
  endtask

  task automatic test_illegal();
    do_access(1'b0, 2'b10, 1'b0, 32'h101, 32'h0, 32'h0, 1, "word_misaligned");
    do_access(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, 32'h0, 1, "size_reserved");
    do_access(1'b1, 2'b01, 1'b0, 32'h303, 32'h0, 32'h0, 1, "half_misaligned");
  endtask

  task automatic test_timeout();
    do_access(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h1111_2222, 0, "timeout");
    do_access(1'b0, 2'b10, 1'b0, 32'h404, 32'h0, 32'h3333_4444, 255, "ack_last_cycle");
  endtask

  task automatic test_reset_mid();
    is_store = 1'b0; access_size = 2'b10; load_signed = 1'b0; address = 32'h40;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    ld_model = '0;
    n_cmp++; if (mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mem_be !== 4'h0) begin n_bad++;
      $display("FAIL reset_mid: got req%b busy%b done%b be%b exp 0 0 0 0000", mem_req, busy, done, mem_be); end
    n_cmp++; if (load_data !== ld_model) begin n_bad++;
      $display("FAIL reset_mid load_data: got %h exp %h", load_data, ld_model); end
    tick(); tick();
    n_cmp++; if (done !== 1'b0 || mem_req !== 1'b0) begin n_bad++;
      $display("FAIL reset_mid held: got done%b req%b exp 00", done, mem_req); end
    rst = 1'b1;
    tick();
    do_access(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 32'hCAFE_F00D, 2, "after_reset");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++)
      do_access(1'(i % 2), 2'(i % 3), 1'b1, 32'h800 + 32'(4 * i), $urandom, $urandom, 1, "b2b");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      do_access(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                int'($urandom_range(1, 5)), "random");
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_byte_load();
    test_half_store();
    test_illegal();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
